// File: rtl/in_debounce.sv
// in_debounce: synchronizes and debounces one raw switch/button level.
// Ports: clk, res (async active-low), in (raw level), out (debounced level),
//        rise (1-cycle pulse as out goes 1), fall (1-cycle pulse as out goes 0).
// Latency: out follows a held input change after DEB_CYCLES+3 rising edges.
// No backpressure: one input, free-running, every cycle is consumed.
// Optional feature: define FALL_PULSE_EN to add the fall port and its register.
// Parameter DEB_CYCLES (1..255): consecutive stable synchronized cycles needed
// beyond the first candidate sample before out changes.

module in_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic res,
  input  logic in,
  output logic out,
  output logic rise
`ifdef FALL_PULSE_EN
  ,
  output logic fall
`endif
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  logic [1:0]    sync_q;
  logic          sync;
  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          out_nxt;
  logic          rise_nxt;
`ifdef FALL_PULSE_EN
  logic          fall_nxt;
`endif

  // Two-flop synchronizer; nothing else looks at the raw input.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], in};
    end
  end

  assign sync = sync_q[1];

  // State register; out/rise/fall are registered from their next values so
  // no output has a combinational path from the input.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= LO;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
`ifdef FALL_PULSE_EN
      fall  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= rise_nxt;
`ifdef FALL_PULSE_EN
      fall  <= fall_nxt;
`endif
    end
  end

  // Next-state logic. The counter saturates at CNT_MAX by construction: the
  // candidate state is left (and cnt cleared) on the cycle cnt reaches it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LO: begin
        if (sync) begin
          state_nxt = CHK_HI;
          cnt_nxt   = '0;
        end
      end
      CHK_HI: begin
        if (!sync) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HI: begin
        if (!sync) begin
          state_nxt = CHK_LO;
          cnt_nxt   = '0;
        end
      end
      CHK_LO: begin
        if (sync) begin
          state_nxt = HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: out holds its level through the candidate states, so it
  // only moves on a confirmed CHK_* -> stable transition.
  always_comb begin
    out_nxt  = (state_nxt == HI) || (state_nxt == CHK_LO);
    rise_nxt = (state == CHK_HI) && (state_nxt == HI);
`ifdef FALL_PULSE_EN
    fall_nxt = (state == CHK_LO) && (state_nxt == LO);
`endif
  end

endmodule

// File: tb/tb_in_debounce.sv
// Testbench for in_debounce: randomized and directed input sequences compared
// cycle by cycle against a run-length reference model.

module tb_in_debounce;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic in  = 1'b0;
  logic out;
  logic rise;
`ifdef FALL_PULSE_EN
  logic fall;
`endif

  always #5 clk = ~clk;

  in_debounce #(.DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .res (res),
    .in  (in),
    .out (out),
    .rise(rise)
`ifdef FALL_PULSE_EN
    ,
    .fall(fall)
`endif
  );

  // Downstream Moore FSM fed by the debounced level.
  logic fsm_q;
  always_ff @(posedge clk or negedge res) begin
    if (!res) fsm_q <= 1'b0;
    else      fsm_q <= out;
  end

  int n_cmp = 0;
  int n_err = 0;
  int dut_rises = 0;

  // Reference model: the input reaches the decision point two edges late;
  // out flips once DEB+1 consecutive delayed samples disagree with it.
  logic m_dly0, m_dly1;
  logic m_out, m_rise, m_fall;
  int   m_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dly0 = 1'b0;
    m_dly1 = 1'b0;
    m_out  = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_run  = 0;
  endtask

  task automatic model_edge(input logic v);
    logic s;
    s      = m_dly1;
    m_dly1 = m_dly0;
    m_dly0 = v;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s != m_out) m_run++;
    else            m_run = 0;
    if (m_run == DEB + 1) begin
      m_out = s;
      m_run = 0;
      if (s) m_rise = 1'b1;
      else   m_fall = 1'b1;
    end
  endtask

  // Present v, let one rising edge sample it, then compare all outputs.
  task automatic cycle(input logic v);
    in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    chk("out", out, m_out);
    chk("rise", rise, m_rise);
`ifdef FALL_PULSE_EN
    chk("fall", fall, m_fall);
`endif
    if (rise === 1'b1) dut_rises++;
  endtask

  // Asynchronous reset between edges: outputs must clear with no clock.
  task automatic do_reset();
    res = 1'b0;
    #1;
    model_reset();
    chk("rst_out", out, 1'b0);
    chk("rst_rise", rise, 1'b0);
`ifdef FALL_PULSE_EN
    chk("rst_fall", fall, 1'b0);
`endif
    @(posedge clk);
    #2;
    res = 1'b1;
  endtask

  // Hold v and count edges until out reaches it; bounded.
  task automatic lat(input string tag, input logic v);
    int n;
    n = 0;
    do begin
      cycle(v);
      n++;
    end while (out !== v && n < 50);
    chk(tag, n, DEB + 3);
  endtask

  task automatic settle(input logic v);
    repeat (DEB + 4) cycle(v);
  endtask

  initial begin
    int r0;
    int out_at, fsm_at, fsm_rises, cyc;
    logic prev_out, prev_fsm;

    #1;
    do_reset();
    chk("reset_out_x", out, 1'b0);

    // Held 1 from reset: out and rise appear after DEB+3 edges.
    lat("lat_rise", 1'b1);
    chk("rise_at_change", rise, 1'b1);
    cycle(1'b1);
    chk("rise_one_cycle", rise, 1'b0);
    settle(1'b1);

    // Held 0 from HI.
    lat("lat_fall", 1'b0);
    settle(1'b0);

    // Glitch of DEB sampled cycles is rejected; DEB+1 is accepted.
    r0 = dut_rises;
    repeat (DEB) cycle(1'b1);
    settle(1'b0);
    chk("glitch_rejected", dut_rises - r0, 0);
    r0 = dut_rises;
    repeat (DEB + 1) cycle(1'b1);
    settle(1'b0);
    chk("pulse_accepted", dut_rises - r0, 1);
    settle(1'b0);

    // From HI: 0,0,1 bounce then 0 held -> restart counting from the last 0.
    settle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    lat("lat_after_bounce", 1'b0);
    settle(1'b0);

    // Reset part way through a candidate-high check, then with in low.
    repeat (5) cycle(1'b1);
    do_reset();
    settle(1'b0);
    chk("after_rst_chk", out, 1'b0);

    // Reset while stable high.
    lat("lat_rise2", 1'b1);
    do_reset();
    settle(1'b0);
    chk("after_rst_hi", out, 1'b0);

    // Bouncy press into the downstream FSM: one clean transition, one cycle late.
    out_at = -1;
    fsm_at = -1;
    fsm_rises = 0;
    cyc = 0;
    prev_out = out;
    prev_fsm = fsm_q;
    for (int i = 0; i < DEB + 12; i++) begin
      if (i < 4) cycle((i % 2) == 0);
      else       cycle(1'b1);
      cyc++;
      if (out === 1'b1 && prev_out === 1'b0 && out_at < 0) out_at = cyc;
      if (fsm_q === 1'b1 && prev_fsm === 1'b0) begin
        fsm_rises++;
        if (fsm_at < 0) fsm_at = cyc;
      end
      prev_out = out;
      prev_fsm = fsm_q;
    end
    chk("chain_rises", fsm_rises, 1);
    chk("chain_delay", fsm_at - out_at, 1);
    settle(1'b0);

    // Randomized runs of random level and length, with occasional resets.
    for (int k = 0; k < 300; k++) begin
      logic v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, DEB + 3);
      repeat (len) cycle(v);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
